// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - register file clear sweep and write/read port arbiter
module reg_file_ctrl #(
   parameter int NREGS         = 32,
   parameter int MAX_WR_STREAK = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_valid,
   input  logic [4:0]  i_wb_reg_num,
   input  logic [31:0] i_wb_val,
   output logic        o_wb_ready,
   input  logic        i_rd_valid,
   input  logic [4:0]  i_rd_reg_num_1,
   input  logic [4:0]  i_rd_reg_num_2,
   output logic        o_rd_ready,
   output logic        o_rd_rsp_valid,
   output logic [31:0] o_rd_rs_1,
   output logic [31:0] o_rd_rs_2,
   output logic        o_rf_op,
   output logic [4:0]  o_rf_reg_num_1,
   output logic [4:0]  o_rf_reg_num_2,
   output logic [4:0]  o_rf_w_reg_num,
   output logic [31:0] o_rf_w_val,
   input  logic [31:0] i_rf_rs_1,
   input  logic [31:0] i_rf_rs_2,
   output logic        o_init_done
);

   localparam int SW = (MAX_WR_STREAK < 1) ? 1 : $clog2(MAX_WR_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);
   localparam logic [4:0]    CNT_LAST   = 5'(NREGS - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rs_1_q, rs_1_d;
   logic [31:0]   rs_2_q, rs_2_d;
   logic          wr_x0, wr_nz, grant_w, grant_r;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         streak_q    <= '0;
         rsp_valid_q <= 1'b0;
         rs_1_q      <= '0;
         rs_2_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         streak_q    <= streak_d;
         rsp_valid_q <= rsp_valid_d;
         rs_1_q      <= rs_1_d;
         rs_2_q      <= rs_2_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      streak_d       = streak_q;
      rsp_valid_d    = 1'b0;
      rs_1_d         = rs_1_q;
      rs_2_d         = rs_2_q;
      wr_x0          = 1'b0;
      wr_nz          = 1'b0;
      grant_w        = 1'b0;
      grant_r        = 1'b0;
      o_wb_ready     = 1'b0;
      o_rd_ready     = 1'b0;
      o_rf_op        = 1'b0;
      o_rf_reg_num_1 = '0;
      o_rf_reg_num_2 = '0;
      o_rf_w_reg_num = '0;
      o_rf_w_val     = '0;

      case (state_q)
         ST_CLEAR: begin
            o_rf_op        = 1'b1;
            o_rf_w_reg_num = cnt_q;
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            // x0 writes are acknowledged without touching the port
            wr_x0   = i_wb_valid && (i_wb_reg_num == 5'd0);
            wr_nz   = i_wb_valid && (i_wb_reg_num != 5'd0);
            grant_w = wr_nz && (!i_rd_valid || (streak_q != STREAK_MAX));
            grant_r = i_rd_valid && !grant_w;

            o_wb_ready = wr_x0 || grant_w;
            o_rd_ready = grant_r;

            if (grant_w) begin
               o_rf_op        = 1'b1;
               o_rf_w_reg_num = i_wb_reg_num;
               o_rf_w_val     = i_wb_val;
               if (!i_rd_valid)
                  streak_d = '0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + SW'(1);
            end else if (grant_r) begin
               o_rf_reg_num_1 = i_rd_reg_num_1;
               o_rf_reg_num_2 = i_rd_reg_num_2;
               streak_d       = '0;
               rsp_valid_d    = 1'b1;
               rs_1_d         = (i_rd_reg_num_1 == 5'd0) ? 32'd0 : i_rf_rs_1;
               rs_2_d         = (i_rd_reg_num_2 == 5'd0) ? 32'd0 : i_rf_rs_2;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign o_rd_rsp_valid = rsp_valid_q;
   assign o_rd_rs_1      = rs_1_q;
   assign o_rd_rs_2      = rs_2_q;
   assign o_init_done    = (state_q == ST_RUN);

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb/tb_reg_file_ctrl.sv - self-checking bench for reg_file_ctrl
module tb_reg_file_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_val = '0;
   logic        wb_ready;
   logic        rd_valid = 1'b0;
   logic [4:0]  rd1 = '0;
   logic [4:0]  rd2 = '0;
   logic        rd_ready;
   logic        rsp_valid;
   logic [31:0] rs1, rs2;
   logic        rf_op;
   logic [4:0]  rf_r1, rf_r2, rf_wreg;
   logic [31:0] rf_wval;
   logic [31:0] rf_rs1, rf_rs2;
   logic        init_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_ctrl #(.NREGS(32), .MAX_WR_STREAK(2)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_valid(wb_valid), .i_wb_reg_num(wb_reg), .i_wb_val(wb_val), .o_wb_ready(wb_ready),
      .i_rd_valid(rd_valid), .i_rd_reg_num_1(rd1), .i_rd_reg_num_2(rd2), .o_rd_ready(rd_ready),
      .o_rd_rsp_valid(rsp_valid), .o_rd_rs_1(rs1), .o_rd_rs_2(rs2),
      .o_rf_op(rf_op), .o_rf_reg_num_1(rf_r1), .o_rf_reg_num_2(rf_r2),
      .o_rf_w_reg_num(rf_wreg), .o_rf_w_val(rf_wval),
      .i_rf_rs_1(rf_rs1), .i_rf_rs_2(rf_rs2), .o_init_done(init_done)
   );

   // Register file model; x0 is poisoned after the sweep so a missing zero-force shows up
   logic [31:0] mem [32];
   logic        poison = 1'b0;
   always @(posedge clk) begin
      if (rf_op === 1'b1) mem[rf_wreg] <= rf_wval;
      else if (poison)    mem[0] <= 32'hBAD0_0000;
   end
   assign rf_rs1 = mem[rf_r1];
   assign rf_rs2 = mem[rf_r2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: expected operands pushed at read grant, popped on the response cycle
   logic [63:0] exp_q[$];
   logic [31:0] shadow [32];
   logic        prev_grant = 1'b0;
   logic        mon_en = 1'b0;
   logic [63:0] e;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, prev_grant});
         if (prev_grant && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_rs_1", rs1, e[63:32]);
            chk("rsp_rs_2", rs2, e[31:0]);
         end
         if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
            prev_grant = 1'b0;
         end else begin
            prev_grant = (rd_ready === 1'b1);
            if (prev_grant) exp_q.push_back({shadow[rd1], shadow[rd2]});
            if (wb_ready === 1'b1 && wb_valid && wb_reg != 5'd0) shadow[wb_reg] = wb_val;
         end
      end
   end

   typedef struct {
      logic        wb_valid;
      logic [4:0]  wb_reg;
      logic [31:0] wb_val;
      logic        rd_valid;
      logic [4:0]  rd1, rd2;
      logic        e_wb_ready, e_rd_ready, e_op;
      logic [4:0]  e_r1, e_r2, e_wreg;
      logic [31:0] e_wval;
      string       name;
   } vec_t;

   vec_t vecs [7];

   task automatic sweep_check();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("sweep_op", {31'd0, rf_op}, 32'd1);
         chk("sweep_wreg", {27'd0, rf_wreg}, i);
         chk("sweep_wval", rf_wval, 32'd0);
         chk("sweep_wb_ready", {31'd0, wb_ready}, 32'd0);
         chk("sweep_rd_ready", {31'd0, rd_ready}, 32'd0);
         chk("sweep_init_done", {31'd0, init_done}, 32'd0);
         chk("sweep_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         if (i < 31) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      wb_valid = 1'b0;
      rd_valid = 1'b0;
      @(negedge clk);
      chk("init_done_rise", {31'd0, init_done}, 32'd1);
   endtask

   initial begin
      logic [6:0] pat;
      int wcnt;
      int cyc;
      vecs[0] = '{1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,          "idle"};
      vecs[1] = '{1'b1, 5'd5, 32'hDEAD_BEEF,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF,  "wr_x5"};
      vecs[2] = '{1'b0, 5'd0, 32'h0,          1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0,          "rd_x5_x0"};
      vecs[3] = '{1'b1, 5'd0, 32'h0000_1234,  1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0,          "x0_wr_plus_rd"};
      vecs[4] = '{1'b1, 5'd7, 32'h7777_0007,  1'b1, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h7777_0007,  "wr_x7_rd_waits"};
      vecs[5] = '{1'b0, 5'd0, 32'h0,          1'b1, 5'd7, 5'd5, 1'b0, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0,          "rd_x7_x5"};
      vecs[6] = '{1'b0, 5'd0, 32'h0,          1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,          "idle_end"};

      // Reset and first sweep, with requests held to show they are ignored
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rs_1", rs1, 32'd0);
      chk("rst_rs_2", rs2, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wb_valid = 1'b1; wb_reg = 5'd9; wb_val = 32'h9999_9999;
      rd_valid = 1'b1; rd1 = 5'd1; rd2 = 5'd2;
      sweep_check();
      poison = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         wb_valid = vecs[i].wb_valid; wb_reg = vecs[i].wb_reg; wb_val = vecs[i].wb_val;
         rd_valid = vecs[i].rd_valid; rd1 = vecs[i].rd1; rd2 = vecs[i].rd2;
         @(negedge clk);
         chk({vecs[i].name, "_wb_ready"}, {31'd0, wb_ready}, {31'd0, vecs[i].e_wb_ready});
         chk({vecs[i].name, "_rd_ready"}, {31'd0, rd_ready}, {31'd0, vecs[i].e_rd_ready});
         chk({vecs[i].name, "_rf_op"}, {31'd0, rf_op}, {31'd0, vecs[i].e_op});
         if (vecs[i].e_op || (!vecs[i].e_wb_ready && !vecs[i].e_rd_ready)) begin
            chk({vecs[i].name, "_wreg"}, {27'd0, rf_wreg}, {27'd0, vecs[i].e_wreg});
            chk({vecs[i].name, "_wval"}, rf_wval, vecs[i].e_wval);
         end
         if (!vecs[i].e_op) begin
            chk({vecs[i].name, "_raddr1"}, {27'd0, rf_r1}, {27'd0, vecs[i].e_r1});
            chk({vecs[i].name, "_raddr2"}, {27'd0, rf_r2}, {27'd0, vecs[i].e_r2});
         end
      end

      // Starvation guard: W W R W W R with both requesters held, then the pending write drains
      pat = 7'b1011011;
      wcnt = 0;
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         wb_valid = 1'b1;
         wb_reg = 5'((wcnt % 4) + 1);
         wb_val = 32'h1000_0000 + 32'(wcnt);
         rd_valid = (c < 6);
         rd1 = 5'd1; rd2 = 5'd2;
         @(negedge clk);
         chk("starve_wb_ready", {31'd0, wb_ready}, {31'd0, pat[c]});
         chk("starve_rd_ready", {31'd0, rd_ready}, {31'd0, !pat[c]});
         if (wb_ready === 1'b1) wcnt++;
      end
      @(posedge clk); #1;
      wb_valid = 1'b0; rd_valid = 1'b0;

      // Idle: operands from the last read (x1=v0, x2=v1) must hold
      cyc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c > 0) begin
            chk("idle_rf_op", {31'd0, rf_op}, 32'd0);
            chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("idle_rs_1", rs1, 32'h1000_0000);
            chk("idle_rs_2", rs2, 32'h1000_0001);
            cyc++;
         end
         @(posedge clk); #1;
      end

      // Reset in the same cycle a read is granted
      rst = 1'b1;
      rd_valid = 1'b1; rd1 = 5'd7; rd2 = 5'd5;
      @(negedge clk);
      chk("midrst_rd_ready", {31'd0, rd_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      wb_valid = 1'b1; wb_reg = 5'd4; wb_val = 32'h4444_4444;
      sweep_check();

      // Registers written before the reset must read back cleared
      @(posedge clk); #1;
      rd_valid = 1'b1; rd1 = 5'd7; rd2 = 5'd5;
      @(negedge clk);
      chk("post_rd_ready", {31'd0, rd_ready}, 32'd1);
      @(posedge clk); #1;
      rd_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("idle_cycles_seen", cyc, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
